// File: rtl/memory_key_pkg.sv
// Shared types for the calculator memory-key front end: FSM states, command
// encoding, the button bundle and the store > clear > recall priority pick.
package memory_key_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef enum logic {
    ST_IDLE         = 1'b0,
    ST_WAIT_RELEASE = 1'b1
  } key_state_e;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_STORE  = 2'd1,
    CMD_CLEAR  = 2'd2,
    CMD_RECALL = 2'd3
  } key_cmd_e;

  typedef struct packed {
    logic recall;
    logic clear;
    logic store;
  } key_vec_t;

  // Store beats clear to match the memory register; recall is lowest.
  function automatic key_cmd_e pick_cmd(input key_vec_t rise);
    if (rise.store)       return CMD_STORE;
    else if (rise.clear)  return CMD_CLEAR;
    else if (rise.recall) return CMD_RECALL;
    else                  return CMD_NONE;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-FF synchroniser, stable-count debouncer and a one-cycle
// rise flag derived from the debounced level.
module key_debouncer
  import memory_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every _d gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign deb  = deb_q;
  assign rise = deb_q & ~deb_prev_q;

endmodule

// File: rtl/memory_key_controller.sv
// Memory-key front end: three debounced buttons feed an arbiter/FSM that issues
// at most one registered command pulse per press, then waits for full release.
module memory_key_controller
  import memory_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic btnStore,
  input  logic btnClear,
  input  logic btnRecall,
  output logic memStore,
  output logic memClear,
  output logic memRecall,
  output logic keyBusy
);

  key_vec_t   deb, rise;
  key_state_e state_q, state_d;
  logic       store_q, store_d;
  logic       clear_q, clear_d;
  logic       recall_q, recall_d;
  logic       busy_q, busy_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_store (
    .clock (clock),
    .reset (reset),
    .raw   (btnStore),
    .deb   (deb.store),
    .rise  (rise.store)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_clear (
    .clock (clock),
    .reset (reset),
    .raw   (btnClear),
    .deb   (deb.clear),
    .rise  (rise.clear)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_recall (
    .clock (clock),
    .reset (reset),
    .raw   (btnRecall),
    .deb   (deb.recall),
    .rise  (rise.recall)
  );

  always_comb begin
    state_d  = state_q;
    store_d  = 1'b0;
    clear_d  = 1'b0;
    recall_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise != '0) begin
          state_d = ST_WAIT_RELEASE;
          case (pick_cmd(rise))
            CMD_STORE:  store_d  = 1'b1;
            CMD_CLEAR:  clear_d  = 1'b1;
            CMD_RECALL: recall_d = 1'b1;
            default:    ;
          endcase
        end
      end
      // Rises seen here are dropped: a press during another hold never queues.
      ST_WAIT_RELEASE: begin
        if (deb == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_WAIT_RELEASE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      clear_q  <= 1'b0;
      recall_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      clear_q  <= clear_d;
      recall_q <= recall_d;
      busy_q   <= busy_d;
    end
  end

  assign memStore  = store_q;
  assign memClear  = clear_q;
  assign memRecall = recall_q;
  assign keyBusy   = busy_q;

endmodule

// File: tb/tb_memory_key_controller.sv
// Bench for memory_key_controller with DEBOUNCE_CYCLES=4: directed scenarios
// followed by random button traffic, all compared against a sample-window model.
module tb_memory_key_controller;

  localparam int DC   = 4;
  localparam int HIST = DC + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btnStore = 1'b0, btnClear = 1'b0, btnRecall = 1'b0;
  logic memStore, memClear, memRecall, keyBusy;

  int checks = 0;
  int errors = 0;

  memory_key_controller #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock     (clock),
    .reset     (reset),
    .btnStore  (btnStore),
    .btnClear  (btnClear),
    .btnRecall (btnRecall),
    .memStore  (memStore),
    .memClear  (memClear),
    .memRecall (memRecall),
    .keyBusy   (keyBusy)
  );

  always #5 clock = ~clock;

  // Reference model: raw samples per edge ([0]=store [1]=clear [2]=recall).
  // A debounced level flips once the DC samples reaching the 2nd sync stage
  // all disagree with it; a command follows the edge after a level rises.
  logic [2:0] hist[$];
  logic [2:0] m_deb, m_deb_prev, exp_cmd;
  logic       m_busy;

  int edge_idx, store_edge, clear_edge, recall_edge;
  int n_store, n_clear, n_recall;
  bit busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [2:0] raw);
    logic [2:0] rise;
    bit         flip;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < HIST; i++) hist.push_back(3'b000);
      m_deb      = '0;
      m_deb_prev = '0;
      m_busy     = 1'b0;
      exp_cmd    = '0;
    end else begin
      rise    = m_deb & ~m_deb_prev;
      exp_cmd = '0;
      if (!m_busy) begin
        if (rise[0])      exp_cmd = 3'b001;
        else if (rise[1]) exp_cmd = 3'b010;
        else if (rise[2]) exp_cmd = 3'b100;
        if (rise != '0) m_busy = 1'b1;
      end else if (m_deb == '0) begin
        m_busy = 1'b0;
      end
      hist.push_front(raw);
      void'(hist.pop_back());
      m_deb_prev = m_deb;
      for (int b = 0; b < 3; b++) begin
        flip = 1'b1;
        for (int i = 2; i < HIST; i++)
          if (hist[i][b] == m_deb[b]) flip = 1'b0;
        if (flip) m_deb[b] = ~m_deb[b];
      end
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] raw);
    @(negedge clock);
    reset = rst;
    {btnRecall, btnClear, btnStore} = raw;
    @(posedge clock);
    model_edge(rst, raw);
    #1;
    check("cmd", {29'd0, memRecall, memClear, memStore}, {29'd0, exp_cmd});
    check("busy", {31'd0, keyBusy}, {31'd0, m_busy});
    if (memStore === 1'b1)  begin n_store++;  store_edge  = edge_idx; end
    if (memClear === 1'b1)  begin n_clear++;  clear_edge  = edge_idx; end
    if (memRecall === 1'b1) begin n_recall++; recall_edge = edge_idx; end
    if (keyBusy === 1'b1) busy_seen = 1'b1;
    edge_idx++;
  endtask

  task automatic hold(input logic [2:0] raw, input int n);
    repeat (n) step(1'b0, raw);
  endtask

  task automatic begin_scenario();
    edge_idx    = 0;
    store_edge  = -1;
    clear_edge  = -1;
    recall_edge = -1;
    n_store     = 0;
    n_clear     = 0;
    n_recall    = 0;
    busy_seen   = 1'b0;
  endtask

  initial begin
    logic [2:0] r;
    int         len;

    begin_scenario();
    repeat (3) step(1'b1, 3'b000);
    check("reset_outputs", {28'd0, memStore, memClear, memRecall, keyBusy}, 32'd0);

    // Clean press of store, held 20 cycles then released.
    begin_scenario();
    hold(3'b001, 20);
    check("clean_store_edge", store_edge, 6);
    check("clean_store_count", n_store, 1);
    check("clean_other_count", n_clear + n_recall, 0);
    check("clean_busy_seen", {31'd0, busy_seen}, 32'd1);
    hold(3'b000, 10);
    check("clean_busy_released", {31'd0, keyBusy}, 32'd0);

    // Bouncing clear, then stable from edge 4.
    begin_scenario();
    step(1'b0, 3'b010); step(1'b0, 3'b000); step(1'b0, 3'b010); step(1'b0, 3'b000);
    hold(3'b010, 12);
    check("bounce_clear_edge", clear_edge, 10);
    check("bounce_clear_count", n_clear, 1);
    hold(3'b000, 10);

    // Store and clear together: only store; then clear alone.
    begin_scenario();
    hold(3'b011, 12);
    check("simul_store_count", n_store, 1);
    check("simul_clear_dropped", n_clear, 0);
    hold(3'b000, 10);
    begin_scenario();
    hold(3'b010, 12);
    check("simul_clear_alone", n_clear, 1);
    hold(3'b000, 10);

    // Store pressed and released while recall is held.
    begin_scenario();
    hold(3'b100, 10);
    check("busy_recall_count", n_recall, 1);
    hold(3'b101, 10);
    hold(3'b100, 8);
    check("busy_store_ignored", n_store, 0);
    hold(3'b000, 10);
    check("busy_dropped", {31'd0, keyBusy}, 32'd0);
    begin_scenario();
    hold(3'b001, 10);
    check("busy_next_store_count", n_store, 1);
    check("busy_next_store_edge", store_edge, 6);
    hold(3'b000, 10);

    // Reset at edges 3-4 with store held throughout.
    begin_scenario();
    repeat (3) step(1'b0, 3'b001);
    repeat (2) step(1'b1, 3'b001);
    check("rst_no_early_pulse", n_store, 0);
    hold(3'b001, 10);
    check("rst_store_edge", store_edge, 11);
    check("rst_store_count", n_store, 1);
    hold(3'b000, 10);

    // Three-cycle glitch on recall.
    begin_scenario();
    hold(3'b100, 3);
    hold(3'b000, 10);
    check("glitch_no_recall", n_recall, 0);
    check("glitch_no_busy", {31'd0, busy_seen}, 32'd0);

    // Random button traffic with occasional resets.
    repeat (160) begin
      r   = 3'($urandom);
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(1, 2)) step(1'b1, r);
      end else begin
        hold(r, len);
      end
    end
    hold(3'b000, 12);
    check("final_idle", {28'd0, memStore, memClear, memRecall, keyBusy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
